// File: rtl/dds_pkg.sv
// Shared constants for the DDS sampling/capture path: defaults, mode range and
// the capture FSM state encoding.
package dds_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 256;
    localparam int unsigned MODE_W     = 4;
    localparam int unsigned MODE_MAX   = 4;
    localparam int unsigned STATE_W    = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARM     = 3'd1;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd2;
    localparam logic [STATE_W-1:0] ST_FETCH   = 3'd3;
    localparam logic [STATE_W-1:0] ST_SEND    = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/sample_ram.sv
// DEPTH x DATA_W simple dual-port RAM with one-cycle registered read (BSRAM).
// Only the read register is reset; array contents survive reset.
module sample_ram
    import dds_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Fg_CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_capture_buffer.sv
// Captures DEPTH DDS samples on Enable strobes after an arm request, tags the
// capture with its decimation mode, then streams it out over valid/ready.
module sample_capture_buffer
    import dds_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic              Ready,
    input  logic              Enable,
    input  logic [MODE_W-1:0] Mode,
    input  logic              Start,
    input  logic [DATA_W-1:0] Sample_in,
    output logic [DATA_W-1:0] Out_data,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [MODE_W-1:0] Mode_tag,
    output logic              Busy,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [STATE_W-1:0] state, state_nxt;
    logic [ADDR_W-1:0]  wr_ptr, wr_ptr_nxt;
    logic [ADDR_W-1:0]  rd_ptr, rd_ptr_nxt;
    logic [MODE_W-1:0]  mode_tag_nxt;
    logic               wr_en_c;
    logic [ADDR_W-1:0]  wr_addr_c;
    logic               rd_en_c;

    sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .Fg_CLK  (Fg_CLK),
        .RESETn  (RESETn),
        .wr_en   (wr_en_c),
        .wr_addr (wr_addr_c),
        .wr_data (Sample_in),
        .rd_en   (rd_en_c),
        .rd_addr (rd_ptr),
        .rd_data (Out_data)
    );

    // Next-state, pointer and RAM-strobe logic
    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        mode_tag_nxt = Mode_tag;
        wr_en_c      = 1'b0;
        wr_addr_c    = wr_ptr;
        rd_en_c      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Ready || Start) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (Enable) begin
                    wr_en_c      = 1'b1;
                    wr_addr_c    = '0;
                    mode_tag_nxt = Mode;
                    wr_ptr_nxt   = PTR_ONE;
                    state_nxt    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (Enable) begin
                    wr_en_c = 1'b1;
                    if (Mode != Mode_tag) begin
                        // Mode switched mid-capture: discard and restart at slot 0
                        wr_addr_c    = '0;
                        mode_tag_nxt = Mode;
                        wr_ptr_nxt   = PTR_ONE;
                    end else if (wr_ptr == PTR_LAST) begin
                        wr_ptr_nxt = '0;
                        state_nxt  = ST_FETCH;
                    end else begin
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                    end
                end
            end
            ST_FETCH: begin
                rd_en_c   = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (Out_ready) begin
                    if (rd_ptr == PTR_LAST) begin
                        rd_ptr_nxt = '0;
                        state_nxt  = ST_DONE;
                    end else begin
                        rd_ptr_nxt = rd_ptr + PTR_ONE;
                        state_nxt  = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            Out_valid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Mode_tag  <= '0;
        end else begin
            Out_valid <= (state_nxt == ST_SEND);
            Busy      <= (state_nxt != ST_IDLE);
            Done      <= (state_nxt == ST_DONE);
            Mode_tag  <= mode_tag_nxt;
        end
    end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed/randomized bench for sample_capture_buffer with a queue-based
// reference of the captured frame and its mode tag.
module tb_sample_capture_buffer;
    import dds_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 8;
    localparam int unsigned AW  = 3;

    logic          Fg_CLK = 1'b0;
    logic          RESETn;
    logic          Ready;
    logic          Enable;
    logic [3:0]    Mode;
    logic          Start;
    logic [DW-1:0] Sample_in;
    logic [DW-1:0] Out_data;
    logic          Out_valid;
    logic          Out_ready;
    logic [3:0]    Mode_tag;
    logic          Busy;
    logic          Done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [3:0]    exp_tag;

    sample_capture_buffer #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .ADDR_W (AW)
    ) dut (
        .Fg_CLK    (Fg_CLK),
        .RESETn    (RESETn),
        .Ready     (Ready),
        .Enable    (Enable),
        .Mode      (Mode),
        .Start     (Start),
        .Sample_in (Sample_in),
        .Out_data  (Out_data),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Mode_tag  (Mode_tag),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    task automatic tick();
        @(posedge Fg_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic arm(input logic r, input logic s);
        Ready = r;
        Start = s;
        tick();
        Ready = 1'b0;
        Start = 1'b0;
    endtask

    // Drive Enable/Sample_in/Mode; model keeps the frame that will be streamed
    task automatic capture(input logic [3:0] m0, input int period, input int chg_after,
                           input logic [3:0] m1, input bit rnd, input bit start_noise);
        int writes;
        logic [DW-1:0] s;
        logic [3:0] m;
        bit en;
        writes = 0;
        exp_q.delete();
        for (int k = 0; k < 3000 && exp_q.size() < DEP; k++) begin
            check("busy_capture", 32'(Busy), 32'd1);
            check("valid_capture", 32'(Out_valid), 32'd0);
            en = (k % period) == 0;
            s  = rnd ? DW'($urandom) : DW'(32'h10 + k);
            m  = (chg_after >= 0 && writes >= chg_after) ? m1 : m0;
            Enable    = en;
            Sample_in = s;
            Mode      = m;
            Start     = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (en) begin
                writes++;
                if (exp_q.size() == 0 || m != exp_tag) begin
                    exp_q.delete();
                    exp_tag = m;
                end
                exp_q.push_back(s);
            end
            tick();
        end
        Enable = 1'b0;
        Start  = 1'b0;
        check("capture_len", 32'(exp_q.size()), 32'(DEP));
        check("mode_tag", 32'(Mode_tag), 32'(exp_tag));
    endtask

    // rdy_mode: 0 always ready, 1 pattern 0,0,1, 2 random
    task automatic drain(input int rdy_mode, input bit noise, input int reset_at, input bit pulse_on_done);
        int idx;
        int ph;
        bit prev_stall;
        bit finished;
        logic [DW-1:0] prev_d;
        idx = 0;
        ph = 0;
        prev_stall = 1'b0;
        finished = 1'b0;
        prev_d = '0;
        for (int k = 0; k < 2000 && !finished; k++) begin
            Ready = 1'b0;
            Start = 1'b0;
            if (Out_valid) begin
                if (idx < int'(DEP)) check("data", 32'(Out_data), 32'(exp_q[idx]));
                else check("overrun", 32'(idx), 32'(DEP - 1));
                check("tag_hold", 32'(Mode_tag), 32'(exp_tag));
                if (prev_stall) check("stable", 32'(Out_data), 32'(prev_d));
                if (idx == reset_at) begin
                    RESETn = 1'b0;
                    tick();
                    RESETn = 1'b1;
                    check("rst_valid", 32'(Out_valid), 32'd0);
                    check("rst_busy", 32'(Busy), 32'd0);
                    check("rst_done", 32'(Done), 32'd0);
                    check("rst_tag", 32'(Mode_tag), 32'd0);
                    check("rst_data", 32'(Out_data), 32'd0);
                    finished = 1'b1;
                    break;
                end
            end
            if (Done) begin
                check("done_after_all", 32'(idx), 32'(DEP));
                check("busy_in_done", 32'(Busy), 32'd1);
                check("valid_in_done", 32'(Out_valid), 32'd0);
                if (pulse_on_done) begin
                    Ready = 1'b1;
                    Start = 1'b1;
                end
                finished = 1'b1;
            end
            case (rdy_mode)
                0: Out_ready = 1'b1;
                1: begin
                    Out_ready = (ph == 2);
                    ph = (ph + 1) % 3;
                end
                default: Out_ready = 1'($urandom_range(0, 1));
            endcase
            if (noise) begin
                Enable    = 1'($urandom);
                Sample_in = DW'($urandom);
                Mode      = 4'($urandom_range(0, MODE_MAX));
                if (!finished) Start = 1'($urandom);
            end
            prev_stall = Out_valid && !Out_ready;
            prev_d     = Out_data;
            if (Out_valid && Out_ready) idx++;
            tick();
        end
        Ready     = 1'b0;
        Start     = 1'b0;
        Enable    = 1'b0;
        Out_ready = 1'b0;
        check("drain_finished", 32'(finished), 32'd1);
        check("done_one_cycle", 32'(Done), 32'd0);
        check("busy_falls", 32'(Busy), 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("idle_done", 32'(Done), 32'd0);
            check("idle_busy", 32'(Busy), 32'd0);
        end
    endtask

    initial begin
        RESETn    = 1'b0;
        Ready     = 1'b0;
        Enable    = 1'b0;
        Mode      = 4'd0;
        Start     = 1'b0;
        Sample_in = '0;
        Out_ready = 1'b0;
        exp_tag   = 4'd0;
        tick();
        tick();
        check("reset_valid", 32'(Out_valid), 32'd0);
        check("reset_data", 32'(Out_data), 32'd0);
        check("reset_tag", 32'(Mode_tag), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        RESETn = 1'b1;
        Enable = 1'b1;
        tick();
        check("idle_enable_ignored", 32'(Busy), 32'd0);
        Enable = 1'b0;

        // Mode 0, Enable every cycle, counter data, always-ready sink
        arm(1'b1, 1'b0);
        capture(4'd0, 1, -1, 4'd0, 1'b0, 1'b0);
        drain(0, 1'b0, -1, 1'b0);

        // Mode 1, Enable every 10 cycles
        arm(1'b1, 1'b0);
        capture(4'd1, 10, -1, 4'd1, 1'b0, 1'b0);
        drain(0, 1'b0, -1, 1'b0);

        // Backpressure 0,0,1 with random data and noisy idle inputs
        arm(1'b1, 1'b0);
        capture(4'd3, 1, -1, 4'd3, 1'b1, 1'b0);
        drain(1, 1'b1, -1, 1'b0);

        // Mode change 0->2 after three samples restarts the capture
        arm(1'b1, 1'b0);
        capture(4'd0, 1, 3, 4'd2, 1'b0, 1'b0);
        drain(0, 1'b0, -1, 1'b0);

        // Start noise during capture/send, then reset in SEND at sample 4
        arm(1'b0, 1'b1);
        capture(4'd4, 2, -1, 4'd4, 1'b1, 1'b1);
        drain(2, 1'b1, 4, 1'b0);

        // Fresh capture after the abandoned dump
        arm(1'b1, 1'b0);
        capture(4'd2, 3, -1, 4'd2, 1'b1, 1'b0);
        drain(2, 1'b0, -1, 1'b0);

        // Ready+Start together; re-arm pulse on the DONE cycle is ignored
        arm(1'b1, 1'b1);
        capture(4'd1, 1, -1, 4'd1, 1'b1, 1'b0);
        drain(2, 1'b1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
